// File: rtl/bpu_perf_ctrl_if.sv
// Command and readout handshake bundle for the branch-predictor perf-counter sequencer.
// The slave side is the sequencer. The master side is the host/debug logic that drives commands and sinks words.
interface bpu_perf_ctrl_if #(
    parameter int unsigned CNT_W    = 32,
    parameter int unsigned WINDOW_W = 32,
    parameter int unsigned IDX_W    = 3
);
    logic                cmd_valid;
    logic                cmd_ready;
    logic [1:0]          cmd_op;
    logic [WINDOW_W-1:0] window_len;
    logic                out_valid;
    logic                out_ready;
    logic [CNT_W-1:0]    out_data;
    logic [IDX_W-1:0]    out_idx;
    logic                out_last;

    modport slave (
        input  cmd_valid, cmd_op, window_len, out_ready,
        output cmd_ready, out_valid, out_data, out_idx, out_last
    );

    modport master (
        output cmd_valid, cmd_op, window_len, out_ready,
        input  cmd_ready, out_valid, out_data, out_idx, out_last
    );
endinterface

// File: rtl/bpu_perf_ctrl.sv
// Run-control and readout sequencer for the branch-predictor performance counters.
// The host sends START/STOP/CLEAR/DUMP. The snapshot is streamed as words: cycle count first, then counters 0..NUM_CNT-1.
module bpu_perf_ctrl #(
    parameter int unsigned NUM_CNT  = 5,
    parameter int unsigned CNT_W    = 32,
    parameter int unsigned WINDOW_W = 32,
    parameter int unsigned IDX_W    = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    bpu_perf_ctrl_if.slave           bus,
    input  logic [NUM_CNT*CNT_W-1:0] i_cnt_in,
    output logic                     o_cnt_en,
    output logic                     o_cnt_clr,
    output logic                     o_busy
);
    localparam int unsigned N_WORDS = NUM_CNT + 1;
    localparam int unsigned SNAP_W  = N_WORDS * CNT_W;

    localparam logic [1:0]          OP_START = 2'b00;
    localparam logic [1:0]          OP_STOP  = 2'b01;
    localparam logic [1:0]          OP_CLEAR = 2'b10;
    localparam logic [1:0]          OP_DUMP  = 2'b11;
    localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(NUM_CNT);
    localparam logic [WINDOW_W-1:0] WIN_ONE  = WINDOW_W'(1);
    localparam logic [CNT_W-1:0]    CNT_MAX  = '1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_SNAP = 2'd2,
        S_DUMP = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [WINDOW_W-1:0] r_win;
    logic [WINDOW_W-1:0] w_win_nxt;
    logic [CNT_W-1:0]    r_cycle;
    logic [CNT_W-1:0]    w_cycle_nxt;
    logic [SNAP_W-1:0]   r_snap;
    logic [SNAP_W-1:0]   w_snap_nxt;
    logic [IDX_W-1:0]    r_idx;
    logic [IDX_W-1:0]    w_idx_nxt;

    logic                r_cmd_ready;
    logic                r_cnt_en;
    logic                r_cnt_clr;
    logic                r_busy;
    logic                r_out_valid;
    logic                r_out_last;
    logic [CNT_W-1:0]    r_out_data;
    logic [IDX_W-1:0]    r_out_idx;

    logic                w_cmd_ready_nxt;
    logic                w_cnt_en_nxt;
    logic                w_cnt_clr_nxt;
    logic                w_busy_nxt;
    logic                w_out_valid_nxt;
    logic                w_out_last_nxt;
    logic [CNT_W-1:0]    w_out_data_nxt;
    logic [IDX_W-1:0]    w_out_idx_nxt;

    logic                w_cmd_fire;
    logic                w_start;
    logic                w_stop;
    logic                w_clear;
    logic                w_dump;
    logic                w_out_fire;
    logic                w_win_last;

    // Command decode. cmd_ready is registered, so at most one command is accepted per cycle.
    assign w_cmd_fire = bus.cmd_valid & r_cmd_ready;
    assign w_start    = w_cmd_fire & (bus.cmd_op == OP_START);
    assign w_stop     = w_cmd_fire & (bus.cmd_op == OP_STOP);
    assign w_clear    = w_cmd_fire & (bus.cmd_op == OP_CLEAR);
    assign w_dump     = w_cmd_fire & (bus.cmd_op == OP_DUMP);
    assign w_out_fire = r_out_valid & bus.out_ready;
    assign w_win_last = (r_win == WIN_ONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_state_nxt = S_RUN;
                end else if (w_dump) begin
                    w_state_nxt = S_SNAP;
                end
            end
            S_RUN: begin
                if (w_stop) begin
                    w_state_nxt = S_IDLE;
                end else if (w_dump || w_win_last) begin
                    w_state_nxt = S_SNAP;
                end
            end
            S_SNAP: w_state_nxt = S_DUMP;
            S_DUMP: begin
                if (w_out_fire && (r_idx == LAST_IDX)) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Window, cycle count, snapshot and readout index.
    // A window count of zero means the run is unbounded and is never decremented.
    always_comb begin
        w_win_nxt     = r_win;
        w_cycle_nxt   = r_cycle;
        w_snap_nxt    = r_snap;
        w_idx_nxt     = r_idx;
        w_cnt_clr_nxt = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_win_nxt = bus.window_len;
                end
                if (w_clear) begin
                    w_cnt_clr_nxt = 1'b1;
                    w_cycle_nxt   = '0;
                end
            end
            S_RUN: begin
                if (r_cycle != CNT_MAX) begin
                    w_cycle_nxt = r_cycle + CNT_W'(1);
                end
                if (r_win != '0) begin
                    w_win_nxt = r_win - WIN_ONE;
                end
                if (w_start) begin
                    w_win_nxt = bus.window_len;
                end
                if (w_clear) begin
                    w_cnt_clr_nxt = 1'b1;
                    w_cycle_nxt   = '0;
                end
            end
            S_SNAP: begin
                w_snap_nxt = {i_cnt_in, r_cycle};
                w_idx_nxt  = '0;
            end
            S_DUMP: begin
                if (w_out_fire) begin
                    w_idx_nxt = (r_idx == LAST_IDX) ? '0 : r_idx + IDX_W'(1);
                end
            end
            default: ;
        endcase
    end

    // Next values of the registered outputs, which follow the next state.
    always_comb begin
        w_cnt_en_nxt    = (w_state_nxt == S_RUN);
        w_busy_nxt      = (w_state_nxt != S_IDLE);
        w_cmd_ready_nxt = (w_state_nxt == S_IDLE) ||
                          ((w_state_nxt == S_RUN) && (w_win_nxt != WIN_ONE));
        w_out_valid_nxt = (w_state_nxt == S_DUMP);
        w_out_data_nxt  = '0;
        w_out_idx_nxt   = '0;
        w_out_last_nxt  = 1'b0;
        if (w_out_valid_nxt) begin
            w_out_data_nxt = w_snap_nxt[w_idx_nxt*CNT_W +: CNT_W];
            w_out_idx_nxt  = w_idx_nxt;
            w_out_last_nxt = (w_idx_nxt == LAST_IDX);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_win       <= '0;
            r_cycle     <= '0;
            r_snap      <= '0;
            r_idx       <= '0;
            r_cmd_ready <= 1'b1;
            r_cnt_en    <= 1'b0;
            r_cnt_clr   <= 1'b0;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_idx   <= '0;
            r_out_last  <= 1'b0;
        end else begin
            r_win       <= w_win_nxt;
            r_cycle     <= w_cycle_nxt;
            r_snap      <= w_snap_nxt;
            r_idx       <= w_idx_nxt;
            r_cmd_ready <= w_cmd_ready_nxt;
            r_cnt_en    <= w_cnt_en_nxt;
            r_cnt_clr   <= w_cnt_clr_nxt;
            r_busy      <= w_busy_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_out_data  <= w_out_data_nxt;
            r_out_idx   <= w_out_idx_nxt;
            r_out_last  <= w_out_last_nxt;
        end
    end

    assign bus.cmd_ready = r_cmd_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_idx   = r_out_idx;
    assign bus.out_last  = r_out_last;
    assign o_cnt_en      = r_cnt_en;
    assign o_cnt_clr     = r_cnt_clr;
    assign o_busy        = r_busy;
endmodule

// File: tb/tb_bpu_perf_ctrl.sv
// Directed bench for bpu_perf_ctrl. It drives inputs 1 time unit after each rising edge and samples outputs at the same point.
// A second, narrow instance with 4-bit counters checks that the cycle count saturates.
module tb_bpu_perf_ctrl;
    localparam int unsigned NUM_CNT  = 5;
    localparam int unsigned CNT_W    = 32;
    localparam int unsigned WINDOW_W = 32;
    localparam int unsigned IDX_W    = 3;
    localparam logic [1:0]  OP_START = 2'b00;
    localparam logic [1:0]  OP_STOP  = 2'b01;
    localparam logic [1:0]  OP_CLEAR = 2'b10;
    localparam logic [1:0]  OP_DUMP  = 2'b11;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bpu_perf_ctrl_if #(.CNT_W(CNT_W), .WINDOW_W(WINDOW_W), .IDX_W(IDX_W)) bus ();
    logic [NUM_CNT*CNT_W-1:0] cnt_in;
    logic                     cnt_en;
    logic                     cnt_clr;
    logic                     busy;

    bpu_perf_ctrl #(.NUM_CNT(NUM_CNT), .CNT_W(CNT_W), .WINDOW_W(WINDOW_W), .IDX_W(IDX_W)) dut (
        .clk(clk), .rst(rst), .bus(bus), .i_cnt_in(cnt_in),
        .o_cnt_en(cnt_en), .o_cnt_clr(cnt_clr), .o_busy(busy)
    );

    bpu_perf_ctrl_if #(.CNT_W(4), .WINDOW_W(8), .IDX_W(1)) mbus ();
    logic [3:0] m_cnt_in;
    logic       m_cnt_en;
    logic       m_cnt_clr;
    logic       m_busy;

    bpu_perf_ctrl #(.NUM_CNT(1), .CNT_W(4), .WINDOW_W(8), .IDX_W(1)) dut_sat (
        .clk(clk), .rst(rst), .bus(mbus), .i_cnt_in(m_cnt_in),
        .o_cnt_en(m_cnt_en), .o_cnt_clr(m_cnt_clr), .o_busy(m_busy)
    );

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] exp_w [6];

    // Stimulus helpers only. They make no comparisons.
    task automatic load_cnt(input logic [31:0] base);
        for (int k = 0; k < 5; k++) begin
            cnt_in[k*32 +: 32] = base + 32'(k) * 32'h0000_0101;
            exp_w[k+1]         = base + 32'(k) * 32'h0000_0101;
        end
    endtask

    task automatic send_cmd(input logic [1:0] op, input logic [31:0] len);
        bus.cmd_valid  = 1'b1;
        bus.cmd_op     = op;
        bus.window_len = len;
        @(posedge clk); #1;
        bus.cmd_valid  = 1'b0;
    endtask

    task automatic wait_valid(input int budget, output int cycles);
        cycles = 0;
        while (!bus.out_valid && cycles < budget) begin
            @(posedge clk); #1;
            cycles++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #12;
        checks++;
        if (cnt_en !== 1'b0 || cnt_clr !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctrl cnt_en=%b cnt_clr=%b busy=%b expected 0/0/0", cnt_en, cnt_clr, busy);
        end
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_last !== 1'b0 || bus.out_data !== 32'h0 || bus.out_idx !== 3'd0) begin
            failures++;
            $display("FAIL reset_out valid=%b last=%b data=%h idx=%0d expected all zero",
                     bus.out_valid, bus.out_last, bus.out_data, bus.out_idx);
        end
        checks++;
        if (bus.cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready cmd_ready=%b expected 1", bus.cmd_ready);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_clear();
        send_cmd(OP_CLEAR, 32'd0);
        checks++;
        if (cnt_clr !== 1'b1 || busy !== 1'b0 || cnt_en !== 1'b0) begin
            failures++;
            $display("FAIL clear_pulse cnt_clr=%b busy=%b cnt_en=%b expected 1/0/0", cnt_clr, busy, cnt_en);
        end
        @(posedge clk); #1;
        checks++;
        if (cnt_clr !== 1'b0) begin
            failures++;
            $display("FAIL clear_width cnt_clr=%b expected 0", cnt_clr);
        end
    endtask

    task automatic test_window();
        int n;
        int en_n;
        load_cnt(32'hA000_0010);
        exp_w[0] = 32'd10;
        send_cmd(OP_START, 32'd10);
        n = 0;
        en_n = 0;
        while (!bus.out_valid && n < 40) begin
            if (cnt_en) en_n++;
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (en_n != 10 || n != 11) begin
            failures++;
            $display("FAIL window_len en_cycles=%0d first_word_at=%0d expected 10/11", en_n, n);
        end
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_idx !== 3'(k) || bus.out_data !== exp_w[k] ||
                bus.out_last !== (k == 5)) begin
                failures++;
                $display("FAIL window_word%0d valid=%b idx=%0d data=%h last=%b expected data=%h",
                         k, bus.out_valid, bus.out_idx, bus.out_data, bus.out_last, exp_w[k]);
            end
            bus.out_ready = 1'b1;
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0 || busy !== 1'b0 || cnt_en !== 1'b0) begin
            failures++;
            $display("FAIL window_end valid=%b busy=%b cnt_en=%b expected 0/0/0", bus.out_valid, busy, cnt_en);
        end
    endtask

    task automatic test_stop_unbounded();
        int n;
        send_cmd(OP_CLEAR, 32'd0);
        load_cnt(32'hB000_0000);
        exp_w[0] = 32'd37;
        send_cmd(OP_START, 32'd0);
        repeat (36) @(posedge clk);
        #1;
        checks++;
        if (cnt_en !== 1'b1 || bus.cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL stop_pre cnt_en=%b cmd_ready=%b expected 1/1", cnt_en, bus.cmd_ready);
        end
        send_cmd(OP_STOP, 32'd0);
        checks++;
        if (cnt_en !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL stop_post cnt_en=%b busy=%b expected 0/0", cnt_en, busy);
        end
        send_cmd(OP_DUMP, 32'd0);
        checks++;
        if (bus.out_valid !== 1'b0 || busy !== 1'b1 || bus.cmd_ready !== 1'b0) begin
            failures++;
            $display("FAIL stop_snap valid=%b busy=%b ready=%b expected 0/1/0", bus.out_valid, busy, bus.cmd_ready);
        end
        wait_valid(10, n);
        // Counters move after the snapshot; the readout must not follow them.
        cnt_in = '1;
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_idx !== 3'(k) || bus.out_data !== exp_w[k] ||
                bus.out_last !== (k == 5) || n != 1) begin
                failures++;
                $display("FAIL stop_word%0d valid=%b idx=%0d data=%h last=%b lat=%0d expected data=%h lat=1",
                         k, bus.out_valid, bus.out_idx, bus.out_data, bus.out_last, n, exp_w[k]);
            end
            bus.out_ready = 1'b1;
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b0;
        load_cnt(32'hB000_0000);
    endtask

    task automatic test_backpressure();
        int n;
        int k;
        logic rdy;
        send_cmd(OP_DUMP, 32'd0);
        wait_valid(10, n);
        k = 0;
        n = 0;
        rdy = 1'b0;
        while (k < 6 && n < 40) begin
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_idx !== 3'(k) || bus.out_data !== exp_w[k] ||
                bus.out_last !== (k == 5)) begin
                failures++;
                $display("FAIL bp_word%0d cyc=%0d valid=%b idx=%0d data=%h last=%b expected data=%h",
                         k, n, bus.out_valid, bus.out_idx, bus.out_data, bus.out_last, exp_w[k]);
            end
            bus.out_ready = rdy;
            @(posedge clk); #1;
            if (rdy) k++;
            rdy = ~rdy;
            n++;
        end
        bus.out_ready = 1'b0;
        checks++;
        if (k != 6 || n != 12 || busy !== 1'b0 || bus.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_end transfers=%0d cycles=%0d busy=%b valid=%b expected 6/12/0/0",
                     k, n, busy, bus.out_valid);
        end
    endtask

    task automatic test_clear_in_run();
        int n;
        int en_n;
        int clr_n;
        int clr_at;
        int rdy_low;
        logic last_rdy;
        load_cnt(32'hC000_0100);
        exp_w[0] = 32'd10;
        send_cmd(OP_START, 32'd30);
        n = 0; en_n = 0; clr_n = 0; clr_at = -1; rdy_low = 0; last_rdy = 1'b1;
        while (!bus.out_valid && n < 60) begin
            if (cnt_en) begin
                en_n++;
                last_rdy = bus.cmd_ready;
                if (!bus.cmd_ready) rdy_low++;
            end
            if (cnt_clr) begin
                clr_n++;
                clr_at = n;
            end
            bus.cmd_valid = (n == 19);
            bus.cmd_op    = OP_CLEAR;
            @(posedge clk); #1;
            n++;
        end
        bus.cmd_valid = 1'b0;
        checks++;
        if (en_n != 30 || clr_n != 1 || clr_at != 20) begin
            failures++;
            $display("FAIL run_clear en=%0d clr_pulses=%0d clr_at=%0d expected 30/1/20", en_n, clr_n, clr_at);
        end
        checks++;
        if (rdy_low != 1 || last_rdy !== 1'b0) begin
            failures++;
            $display("FAIL run_final_ready lows=%0d last=%b expected 1/0", rdy_low, last_rdy);
        end
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_idx !== 3'(k) || bus.out_data !== exp_w[k] ||
                bus.out_last !== (k == 5) || cnt_clr !== 1'b0) begin
                failures++;
                $display("FAIL runclr_word%0d valid=%b idx=%0d data=%h last=%b clr=%b expected data=%h",
                         k, bus.out_valid, bus.out_idx, bus.out_data, bus.out_last, cnt_clr, exp_w[k]);
            end
            bus.out_ready = 1'b1;
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_dump();
        int n;
        load_cnt(32'hD000_0000);
        send_cmd(OP_DUMP, 32'd0);
        wait_valid(10, n);
        bus.out_ready = 1'b1;
        n = 0;
        while (bus.out_idx != 3'd3 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        bus.out_ready = 1'b0;
        checks++;
        if (bus.out_idx !== 3'd3 || bus.out_valid !== 1'b1) begin
            failures++;
            $display("FAIL rst_reach idx=%0d valid=%b expected 3/1", bus.out_idx, bus.out_valid);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || busy !== 1'b0 || bus.out_idx !== 3'd0 ||
            bus.out_data !== 32'h0 || bus.cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL rst_mid valid=%b busy=%b idx=%0d data=%h ready=%b expected 0/0/0/0/1",
                     bus.out_valid, busy, bus.out_idx, bus.out_data, bus.cmd_ready);
        end
        #2 rst = 1'b0;
        load_cnt(32'h0);
        exp_w[0] = 32'd0;
        @(posedge clk); #1;
        send_cmd(OP_DUMP, 32'd0);
        wait_valid(10, n);
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_idx !== 3'(k) || bus.out_data !== exp_w[k]) begin
                failures++;
                $display("FAIL rst_word%0d valid=%b idx=%0d data=%h expected data=%h",
                         k, bus.out_valid, bus.out_idx, bus.out_data, exp_w[k]);
            end
            bus.out_ready = 1'b1;
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b0;
    endtask

    task automatic test_saturation(input logic do_clear, input logic [7:0] len, input logic [3:0] exp0);
        int n;
        if (do_clear) begin
            mbus.cmd_valid = 1'b1;
            mbus.cmd_op    = OP_CLEAR;
            @(posedge clk); #1;
            mbus.cmd_valid = 1'b0;
            checks++;
            if (m_cnt_clr !== 1'b1) begin
                failures++;
                $display("FAIL sat_clear cnt_clr=%b expected 1", m_cnt_clr);
            end
        end
        mbus.cmd_valid  = 1'b1;
        mbus.cmd_op     = OP_START;
        mbus.window_len = len;
        @(posedge clk); #1;
        mbus.cmd_valid  = 1'b0;
        n = 0;
        while (!mbus.out_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (mbus.out_valid !== 1'b1 || mbus.out_idx !== 1'b0 || mbus.out_data !== exp0 || m_cnt_en !== 1'b0) begin
            failures++;
            $display("FAIL sat_word0 len=%0d valid=%b idx=%0d data=%h cnt_en=%b expected data=%h",
                     len, mbus.out_valid, mbus.out_idx, mbus.out_data, m_cnt_en, exp0);
        end
        mbus.out_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (mbus.out_idx !== 1'b1 || mbus.out_data !== m_cnt_in || mbus.out_last !== 1'b1) begin
            failures++;
            $display("FAIL sat_word1 idx=%0d data=%h last=%b expected 1/%h/1",
                     mbus.out_idx, mbus.out_data, mbus.out_last, m_cnt_in);
        end
        @(posedge clk); #1;
        mbus.out_ready = 1'b0;
        checks++;
        if (m_busy !== 1'b0 || mbus.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL sat_end busy=%b valid=%b expected 0/0", m_busy, mbus.out_valid);
        end
    endtask

    initial begin
        bus.cmd_valid  = 1'b0;
        bus.cmd_op     = 2'b00;
        bus.window_len = '0;
        bus.out_ready  = 1'b0;
        mbus.cmd_valid  = 1'b0;
        mbus.cmd_op     = 2'b00;
        mbus.window_len = '0;
        mbus.out_ready  = 1'b0;
        cnt_in   = '0;
        m_cnt_in = 4'h9;
        test_reset();
        test_clear();
        test_window();
        test_stop_unbounded();
        test_backpressure();
        test_clear_in_run();
        test_reset_mid_dump();
        test_saturation(1'b1, 8'd14, 4'hE);
        test_saturation(1'b0, 8'd3, 4'hF);
        test_saturation(1'b1, 8'd20, 4'hF);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end
endmodule
